// File: rtl/uart_loader_pkg.sv
// Shared types for the UART program loader: FSM state encoding, word type
// and the number of bytes per image word.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        SUM,
        DONE,
        ERROR
    } loader_state_t;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/uart_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master side is the loader; the slave side is the UART/memory environment.
interface uart_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    import uart_loader_pkg::*;

    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  byte_take;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    word_t                 mem_wdata;

    modport master (
        input  byte_data,
        input  byte_ready,
        output byte_take,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output byte_data,
        output byte_ready,
        input  byte_take,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/uart_byte_packer.sv
// Packs big-endian bytes into 32-bit words. The completed word is presented
// combinationally together with word_valid while the 4th byte is accepted, so
// the consumer can register it on the same edge that consumes that byte.
module uart_byte_packer
    import uart_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output word_t      word,
    output logic       word_valid
);
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    assign word       = {shift_q, in_data};
    assign word_valid = in_valid && (cnt_q == 2'(WORD_BYTES - 1));

    // Shift in accepted bytes; the byte counter wraps 3->0 on word completion.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (in_valid) begin
            shift_q <= word[23:0];
            cnt_q   <= cnt_q + 2'd1;
        end
    end
endmodule

// File: rtl/uart_program_loader.sv
// Loads a program image (length word N, then N big-endian data words) from the
// UART receive stream into instruction memory. Optional feature macro:
// UART_LOADER_CHECKSUM_EN adds a trailing checksum word (sum of data words
// modulo 2**32) that must match for the load to end in DONE.
module uart_program_loader
    import uart_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    uart_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error
);
    localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

    loader_state_t         state_q, state_d;
    word_t                 word;
    logic                  word_valid;
    logic                  accept;
    logic                  last_word;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_p1;
    word_t                 wdata_p1;
`ifdef UART_LOADER_CHECKSUM_EN
    word_t                 sum_q;
`endif

    assign busy   = (state_q == LEN) || (state_q == DATA) || (state_q == SUM);
    assign done   = (state_q == DONE);
    assign error  = (state_q == ERROR);
    assign accept = bus.byte_ready && busy;

    assign bus.byte_take = accept;
    assign bus.mem_we    = we_p1;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_p1;

    // cnt_q counts words already captured, so this word is the Nth one.
    assign last_word = ((cnt_q + (ADDR_WIDTH + 1)'(1)) == len_q);

    // Packer is held clear whenever no load is running, dropping partial words.
    uart_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (!busy),
        .in_valid   (accept),
        .in_data    (bus.byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; IDLE falls straight into LEN so the core boots after reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = LEN;
            LEN: begin
                if (word_valid) begin
                    if (word == '0)                   state_d = DONE;
                    else if ({1'b0, word} > CAPACITY) state_d = ERROR;
                    else                              state_d = DATA;
                end
            end
            DATA: begin
                if (word_valid && last_word) begin
`ifdef UART_LOADER_CHECKSUM_EN
                    state_d = SUM;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            SUM: begin
                if (word_valid) state_d = (word == sum_q) ? DONE : ERROR;
            end
`endif
            DONE, ERROR: begin
                if (start) state_d = LEN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Length latch, word counter, write stage and address; address advances after each write.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= BASE_ADDR;
            we_p1    <= 1'b0;
            wdata_p1 <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            we_p1 <= (state_q == DATA) && word_valid;
            if (state_q == LEN && word_valid) len_q <= word[ADDR_WIDTH:0];
            if (state_q == DATA && word_valid) begin
                wdata_p1 <= word;
                cnt_q    <= cnt_q + (ADDR_WIDTH + 1)'(1);
`ifdef UART_LOADER_CHECKSUM_EN
                sum_q    <= sum_q + word;
`endif
            end
            if (!busy) begin
                cnt_q  <= '0;
                addr_q <= BASE_ADDR;
`ifdef UART_LOADER_CHECKSUM_EN
                sum_q  <= '0;
`endif
            end else if (we_p1) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: a 12-bit-address instance (BASE 0)
// and a 4-bit-address instance (BASE 14) exercising length limits and wrap.
module tb_uart_program_loader;
    import uart_loader_pkg::*;

    logic clk = 1'b0;
    logic reset_b, reset_s, start_b, start_s;
    logic busy_b, done_b, error_b, busy_s, done_s, error_s;

    always #5 clk = ~clk;

    uart_loader_if #(.ADDR_WIDTH(12)) ifb ();
    uart_loader_if #(.ADDR_WIDTH(4))  ifs ();

    uart_program_loader #(.ADDR_WIDTH(12), .BASE_ADDR(12'd0)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .start (start_b),
        .bus   (ifb),
        .busy  (busy_b),
        .done  (done_b),
        .error (error_b)
    );

    uart_program_loader #(.ADDR_WIDTH(4), .BASE_ADDR(4'd14)) dut_s (
        .clk   (clk),
        .reset (reset_s),
        .start (start_s),
        .bus   (ifs),
        .busy  (busy_s),
        .done  (done_s),
        .error (error_s)
    );

    int errors = 0;
    int checks = 0;

    logic [11:0] wa_b[$];
    word_t       wd_b[$];
    logic [3:0]  wa_s[$];
    word_t       wd_s[$];
    word_t       img[$];
    int          pulse_err = 0;
    int          take_viol = 0;
    logic        prev_we_b = 1'b0;
    logic        prev_we_s = 1'b0;

    // Write log, write-pulse length and byte_take/byte_ready monitor.
    always @(negedge clk) begin
        if (ifb.mem_we) begin
            wa_b.push_back(ifb.mem_addr);
            wd_b.push_back(ifb.mem_wdata);
        end
        if (ifs.mem_we) begin
            wa_s.push_back(ifs.mem_addr);
            wd_s.push_back(ifs.mem_wdata);
        end
        if ((ifb.mem_we && prev_we_b) || (ifs.mem_we && prev_we_s)) pulse_err <= pulse_err + 1;
        if ((ifb.byte_take && !ifb.byte_ready) || (ifs.byte_take && !ifs.byte_ready))
            take_viol <= take_viol + 1;
        prev_we_b <= ifb.mem_we;
        prev_we_s <= ifs.mem_we;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte after gap idle cycles and hold it until consumed.
    task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
        int n;
        if (sel) ifs.byte_ready = 1'b0; else ifb.byte_ready = 1'b0;
        repeat (gap) @(negedge clk);
        if (sel) begin ifs.byte_data = b; ifs.byte_ready = 1'b1; end
        else     begin ifb.byte_data = b; ifb.byte_ready = 1'b1; end
        #1;
        n = 0;
        while (!(sel ? ifs.byte_take : ifb.byte_take) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $error("FAIL take_timeout: byte %0h never consumed within 40 cycles", b);
        end
        @(negedge clk);
        if (sel) ifs.byte_ready = 1'b0; else ifb.byte_ready = 1'b0;
    endtask

    task automatic send_word(input bit sel, input word_t w, input int gmax);
        for (int i = 3; i >= 0; i--)
            send_byte(sel, w[8*i +: 8], (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0);
    endtask

    // Length word, the data words in img and, with the checksum feature, their sum.
    task automatic send_image(input bit sel, input int gmax);
        word_t s;
        s = '0;
        send_word(sel, word_t'(img.size()), gmax);
        foreach (img[i]) begin
            send_word(sel, img[i], gmax);
            s = s + img[i];
        end
`ifdef UART_LOADER_CHECKSUM_EN
        send_word(sel, s, gmax);
`endif
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start_s = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        if (sel) start_s = 1'b0; else start_b = 1'b0;
    endtask

    initial begin
        reset_b = 1'b1; reset_s = 1'b1; start_b = 1'b0; start_s = 1'b0;
        ifb.byte_data = '0; ifb.byte_ready = 1'b0;
        ifs.byte_data = '0; ifs.byte_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values, with byte_ready high to prove byte_take is gated.
        ifb.byte_ready = 1'b1;
        #1;
        chk("rst_take",  ifb.byte_take, 0);
        chk("rst_we",    ifb.mem_we,    0);
        chk("rst_addr",  ifb.mem_addr,  0);
        chk("rst_wdata", ifb.mem_wdata, 0);
        chk("rst_busy",  busy_b,        0);
        chk("rst_done",  done_b,        0);
        chk("rst_error", error_b,       0);
        @(negedge clk);
        reset_b = 1'b0; reset_s = 1'b0;
        #1;
        chk("idle_take", ifb.byte_take, 0);
        @(negedge clk);
        #1;
        chk("boot_busy", busy_b, 1);
        chk("boot_take", ifb.byte_take, 1);

        // Test 1: two-word image, exact write timing.
        send_word(0, 32'd2, 0);
        send_word(0, 32'hDEADBEEF, 0);
        #1;
        chk("t1_we0",    ifb.mem_we,    1);
        chk("t1_addr0",  ifb.mem_addr,  0);
        chk("t1_data0",  ifb.mem_wdata, 32'hDEADBEEF);
        send_word(0, 32'h01234567, 0);
        #1;
        chk("t1_we1",    ifb.mem_we,    1);
        chk("t1_addr1",  ifb.mem_addr,  1);
        chk("t1_data1",  ifb.mem_wdata, 32'h01234567);
`ifdef UART_LOADER_CHECKSUM_EN
        chk("t1_sum_busy", busy_b, 1);
        send_word(0, 32'hDFD10456, 0);
        #1;
`endif
        chk("t1_done",   done_b, 1);
        chk("t1_busy",   busy_b, 0);
        @(negedge clk);
        #1;
        chk("t1_we_off", ifb.mem_we, 0);
        chk("t1_nwr",    wa_b.size(), 2);
        ifb.byte_ready = 1'b1;
        #1;
        chk("t1_stall",  ifb.byte_take, 0);
        ifb.byte_ready = 1'b0;

        // Test 2: empty image, then a one-word image after start.
        pulse_start(0);
        chk("t2_done_clr", done_b, 0);
        send_word(0, 32'd0, 0);
        #1;
        chk("t2_done0", done_b, 1);
        chk("t2_nwr0",  wa_b.size(), 2);
        pulse_start(0);
        img.delete();
        img.push_back(32'hCAFEBABE);
        send_image(0, 0);
        #1;
        chk("t2_done1", done_b, 1);
        chk("t2_nwr1",  wa_b.size(), 3);
        chk("t2_addr",  wa_b[2], 0);
        chk("t2_data",  wd_b[2], 32'hCAFEBABE);

        // Test 4: test 1 stream with random byte_ready gaps.
        pulse_start(0);
        img.delete();
        img.push_back(32'hDEADBEEF);
        img.push_back(32'h01234567);
        send_image(0, 5);
        #1;
        chk("t4_done",  done_b, 1);
        chk("t4_nwr",   wa_b.size(), 5);
        chk("t4_addr0", wa_b[3], 0);
        chk("t4_data0", wd_b[3], 32'hDEADBEEF);
        chk("t4_addr1", wa_b[4], 1);
        chk("t4_data1", wd_b[4], 32'h01234567);

        // Test 5: reset after six bytes, then a clean reload.
        pulse_start(0);
        send_word(0, 32'd2, 0);
        send_byte(0, 8'hDE, 0);
        send_byte(0, 8'hAD, 0);
        reset_b = 1'b1;
        ifb.byte_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("t5_take",  ifb.byte_take, 0);
        chk("t5_we",    ifb.mem_we,    0);
        chk("t5_addr",  ifb.mem_addr,  0);
        chk("t5_wdata", ifb.mem_wdata, 0);
        chk("t5_busy",  busy_b,        0);
        chk("t5_done",  done_b,        0);
        chk("t5_error", error_b,       0);
        reset_b = 1'b0;
        ifb.byte_ready = 1'b0;
        send_image(0, 0);
        #1;
        chk("t5_nwr",   wa_b.size(), 7);
        chk("t5_addr0", wa_b[5], 0);
        chk("t5_data0", wd_b[5], 32'hDEADBEEF);
        chk("t5_addr1", wa_b[6], 1);
        chk("t5_data1", wd_b[6], 32'h01234567);
        chk("t5_done1", done_b, 1);

        // Test 3: 4-bit address instance, length 17 is rejected.
        send_word(1, 32'h00000011, 0);
        #1;
        chk("t3_error", error_s, 1);
        chk("t3_busy",  busy_s,  0);
        chk("t3_nwr",   wa_s.size(), 0);
        ifs.byte_ready = 1'b1;
        #1;
        chk("t3_take",  ifs.byte_take, 0);
        ifs.byte_ready = 1'b0;

        // Length 16 is exactly capacity and must be accepted.
        pulse_start(1);
        chk("t3_err_clr", error_s, 0);
        send_word(1, 32'h00000010, 0);
        #1;
        chk("t3_cap_busy",  busy_s,  1);
        chk("t3_cap_error", error_s, 0);
        reset_s = 1'b1;
        @(negedge clk);
        reset_s = 1'b0;

        // Address wrap: BASE 14 with three words writes 14, 15, 0.
        img.delete();
        img.push_back(32'h11111111);
        img.push_back(32'h22222222);
        img.push_back(32'h33333333);
        send_image(1, 1);
        #1;
        chk("wrap_done", done_s, 1);
        chk("wrap_nwr",  wa_s.size(), 3);
        chk("wrap_a0",   wa_s[0], 14);
        chk("wrap_a1",   wa_s[1], 15);
        chk("wrap_a2",   wa_s[2], 0);
        chk("wrap_d2",   wd_s[2], 32'h33333333);

`ifdef UART_LOADER_CHECKSUM_EN
        // Test 6: wrong checksum ends in ERROR after the data is written.
        pulse_start(0);
        send_word(0, 32'd2, 0);
        send_word(0, 32'hDEADBEEF, 0);
        send_word(0, 32'h01234567, 0);
        send_word(0, 32'hDFD10457, 0);
        #1;
        chk("t6_error", error_b, 1);
        chk("t6_done",  done_b,  0);
        chk("t6_nwr",   wa_b.size(), 9);
        chk("t6_data1", wd_b[8], 32'h01234567);
`endif

        @(negedge clk);
        #1;
        chk("we_pulse_len", pulse_err, 0);
        chk("take_no_ready", take_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
